ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. It consumes ID/EX outputs and produces the EX/MEM register that feeds the memory stage.
- Memory-stage inputs it supplies: address/ALU result, store data, destination register, memread/memwrite, branch control, zero, WB control.
- Contains the ALU, branch-target adder, destination-register mux and EX/MEM register.
- Also contains an iterative 32-cycle shift-add multiplier that stalls upstream via ex_busy.

---
 rtl/ex_stage.sv | 168 ++++++++++++++++
 tb/tb_ex_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, branch-target adder, destination mux,
// iterative shift-add multiplier and the EX/MEM register. Optional forwarding muxes: EX_FORWARD_EN.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ex_wb_ctl,
  input  logic [2:0]  ex_m_ctl,
  input  logic [1:0]  ex_alu_op,
  input  logic [5:0]  ex_funct,
  input  logic        ex_alusrc,
  input  logic        ex_regdst,
  input  logic [31:0] ex_npc,
  input  logic [31:0] ex_rdata1,
  input  logic [31:0] ex_rdata2,
  input  logic [31:0] ex_sign_ext,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic [1:0]  ex_mem_wb_ctl,
  output logic        ex_mem_branch,
  output logic        ex_mem_memread,
  output logic        ex_mem_memwrite,
  output logic [31:0] ex_mem_add_result,
  output logic        ex_mem_zero,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_write_data,
  output logic [4:0]  ex_mem_write_reg,
  output logic        ex_busy
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

  typedef struct packed {
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
  } ex_mem_t;

  mul_state_t    state;
  logic [CW-1:0] count;
  logic [31:0]   mul_a, mul_b, acc;
  ex_mem_t       ex_mem, nxt;

  logic [31:0] op_a, rdata2_final, op_b, alu_result, result_final;
  logic        is_mult, take_bubble;

`ifdef EX_FORWARD_EN
  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] mem_val, input logic [31:0] wb_val);
    case (sel)
      2'b10:   return mem_val;
      2'b01:   return wb_val;
      default: return reg_val;
    endcase
  endfunction

  assign op_a         = fwd_sel(fwd_a, ex_rdata1, mem_fwd_data, wb_fwd_data);
  assign rdata2_final = fwd_sel(fwd_b, ex_rdata2, mem_fwd_data, wb_fwd_data);
`else
  logic unused_fwd;
  assign unused_fwd   = ^{fwd_a, fwd_b, mem_fwd_data, wb_fwd_data};
  assign op_a         = ex_rdata1;
  assign rdata2_final = ex_rdata2;
`endif

  assign op_b    = ex_alusrc ? ex_sign_ext : rdata2_final;
  assign is_mult = (ex_alu_op == 2'b10) && (ex_funct == 6'h18);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_result = '0;
    case (ex_alu_op)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b10: begin
        case (ex_funct)
          6'h20:   alu_result = op_a + op_b;
          6'h22:   alu_result = op_a - op_b;
          6'h24:   alu_result = op_a & op_b;
          6'h25:   alu_result = op_a | op_b;
          6'h2A:   alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
          // mult's product comes from the iterative unit in DONE, not from this mux
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign result_final = (state == DONE) ? acc : alu_result;
  assign take_bubble  = flush || (state == MUL) || (state == IDLE && is_mult);
  assign ex_busy      = reset && ((state == MUL) || (state == IDLE && is_mult && !flush));

  always_comb begin
    nxt = '0;
    if (!take_bubble) begin
      nxt.wb_ctl                           = ex_wb_ctl;
      {nxt.branch, nxt.memread, nxt.memwrite} = ex_m_ctl;
      nxt.add_result                       = ex_npc + {ex_sign_ext[29:0], 2'b00};
      nxt.zero                             = (result_final == '0);
      nxt.alu_result                       = result_final;
      nxt.write_data                       = rdata2_final;
      nxt.write_reg                        = ex_regdst ? ex_rd : ex_rt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      acc    <= '0;
      ex_mem <= '0;
    end else begin
      ex_mem <= nxt;
      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: if (is_mult) begin
            mul_a <= op_a;
            mul_b <= op_b;
            acc   <= '0;
            count <= '0;
            state <= MUL;
          end
          MUL: begin
            if (mul_b[0]) acc <= acc + mul_a;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            count <= count + CW'(1);
            if (count == CW'(MUL_CYCLES - 1)) state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ex_mem_wb_ctl     = ex_mem.wb_ctl;
  assign ex_mem_branch     = ex_mem.branch;
  assign ex_mem_memread    = ex_mem.memread;
  assign ex_mem_memwrite   = ex_mem.memwrite;
  assign ex_mem_add_result = ex_mem.add_result;
  assign ex_mem_zero       = ex_mem.zero;
  assign ex_mem_alu_result = ex_mem.alu_result;
  assign ex_mem_write_data = ex_mem.write_data;
  assign ex_mem_write_reg  = ex_mem.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branch target, multiplier timing, flush and async reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ex_wb_ctl, ex_alu_op, fwd_a, fwd_b;
  logic [2:0]  ex_m_ctl;
  logic [5:0]  ex_funct;
  logic        ex_alusrc, ex_regdst, flush;
  logic [31:0] ex_npc, ex_rdata1, ex_rdata2, ex_sign_ext, mem_fwd_data, wb_fwd_data;
  logic [4:0]  ex_rt, ex_rd;
  logic [1:0]  ex_mem_wb_ctl;
  logic        ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_zero, ex_busy;
  logic [31:0] ex_mem_add_result, ex_mem_alu_result, ex_mem_write_data;
  logic [4:0]  ex_mem_write_reg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .ex_wb_ctl(ex_wb_ctl), .ex_m_ctl(ex_m_ctl), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_npc(ex_npc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_sign_ext(ex_sign_ext),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_mem_wb_ctl(ex_mem_wb_ctl), .ex_mem_branch(ex_mem_branch),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_add_result(ex_mem_add_result), .ex_mem_zero(ex_mem_zero),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_write_data(ex_mem_write_data),
    .ex_mem_write_reg(ex_mem_write_reg), .ex_busy(ex_busy)
  );

  logic [106:0] outs;
  assign outs = {ex_mem_wb_ctl, ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_add_result,
                 ex_mem_zero, ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg};

  task automatic check(input string tag, input logic [106:0] obs, input logic [106:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    ex_wb_ctl = 2'b00; ex_m_ctl = 3'b000; ex_alu_op = 2'b00; ex_funct = 6'h00;
    ex_alusrc = 1'b0; ex_regdst = 1'b0; ex_npc = '0; ex_rdata1 = '0; ex_rdata2 = '0;
    ex_sign_ext = '0; ex_rt = '0; ex_rd = '0; flush = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00; mem_fwd_data = '0; wb_fwd_data = '0;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    nop();
    ex_alu_op = 2'b10; ex_funct = funct; ex_rdata1 = a; ex_rdata2 = b;
    ex_regdst = 1'b1; ex_rd = 5'd3; ex_rt = 5'd9; ex_wb_ctl = 2'b10;
  endtask

  task automatic lw();
    nop();
    ex_alusrc = 1'b1; ex_rdata1 = 32'h1000; ex_sign_ext = 32'h4; ex_rdata2 = 32'h55;
    ex_m_ctl = 3'b010; ex_wb_ctl = 2'b11; ex_rt = 5'd8;
  endtask

  initial begin
    int busy_cycles, bubbles, hits, busy_seen;
    logic [31:0] fwd_exp;

    nop();
    reset = 1'b0;
    #3;
    check("reset_outs", outs, '0);
    check("reset_busy", ex_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    lw();
    step();
    check("lw_alu", ex_mem_alu_result, 32'h1004);
    check("lw_memread", ex_mem_memread, 1'b1);
    check("lw_wreg", ex_mem_write_reg, 5'd8);
    check("lw_zero", ex_mem_zero, 1'b0);
    check("lw_wb", ex_mem_wb_ctl, 2'b11);
    check("lw_wdata", ex_mem_write_data, 32'h55);
    check("lw_addr", ex_mem_add_result, 32'h10);

    nop();
    ex_alu_op = 2'b01; ex_rdata1 = 32'd5; ex_rdata2 = 32'd5; ex_npc = 32'h40;
    ex_sign_ext = 32'd3; ex_m_ctl = 3'b100;
    step();
    check("beq_zero", ex_mem_zero, 1'b1);
    check("beq_target", ex_mem_add_result, 32'h4C);
    check("beq_branch", ex_mem_branch, 1'b1);
    ex_rdata2 = 32'd6;
    step();
    check("bne_zero", ex_mem_zero, 1'b0);
    check("bne_diff", ex_mem_alu_result, 32'hFFFF_FFFF);

    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1);
    step();
    check("slt_neg", ex_mem_alu_result, 32'd1);
    check("slt_wreg", ex_mem_write_reg, 5'd3);
    rtype(6'h2A, 32'd1, 32'hFFFF_FFFF);
    step();
    check("slt_pos", ex_mem_alu_result, 32'd0);
    rtype(6'h24, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    step();
    check("and", ex_mem_alu_result, 32'h00F0_000F);
    rtype(6'h25, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    step();
    check("or", ex_mem_alu_result, 32'hFFF0_0FFF);
    rtype(6'h22, 32'd3, 32'd5);
    step();
    check("sub", ex_mem_alu_result, 32'hFFFF_FFFE);
    rtype(6'h20, 32'hFFFF_FFFF, 32'd2);
    step();
    check("add_wrap", ex_mem_alu_result, 32'd1);
    rtype(6'h27, 32'd7, 32'd9);
    step();
    check("bad_funct", {ex_mem_alu_result, ex_mem_zero}, {32'd0, 1'b1});
    rtype(6'h20, 32'd7, 32'd9);
    ex_alu_op = 2'b11;
    step();
    check("aluop11", ex_mem_alu_result, 32'd0);

    nop();
    ex_alusrc = 1'b1; ex_sign_ext = 32'd1; ex_rdata1 = 32'd99;
    fwd_a = 2'b10; mem_fwd_data = 32'd7;
`ifdef EX_FORWARD_EN
    fwd_exp = 32'd8;
`else
    fwd_exp = 32'd100;
`endif
    step();
    check("fwd_a", ex_mem_alu_result, fwd_exp);

    rtype(6'h18, 32'h1234_5678, 32'h10);
    ex_rd = 5'd5;
    #1;
    check("mul_busy_comb", ex_busy, 1'b1);
    busy_cycles = 0;
    bubbles = 0;
    for (int i = 0; i < 100 && ex_busy; i++) begin
      busy_cycles++;
      step();
      if (outs == '0) bubbles++;
    end
    check("mul_busy_cycles", busy_cycles, 33);
    check("mul_bubbles", bubbles, 33);
    step();
    check("mul_result", ex_mem_alu_result, 32'h2345_6780);
    check("mul_wreg", {ex_mem_wb_ctl, ex_mem_write_reg, ex_mem_zero}, {2'b10, 5'd5, 1'b0});
    nop();

    rtype(6'h18, 32'd3, 32'd5);
    repeat (10) step();
    check("mul2_busy", ex_busy, 1'b1);
    flush = 1'b1;
    step();
    check("flush_bubble", outs, '0);
    nop();
    ex_alusrc = 1'b1; ex_rdata1 = 32'd20; ex_sign_ext = 32'd2;
    #1;
    check("flush_idle", ex_busy, 1'b0);
    hits = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_mem_alu_result == 32'd15) hits++;
      if (ex_busy) busy_seen++;
    end
    check("flush_no_result", hits, 0);
    check("flush_no_busy", busy_seen, 0);
    check("post_flush_add", ex_mem_alu_result, 32'd22);

    rtype(6'h18, 32'd3, 32'd5);
    repeat (5) step();
    reset = 1'b0;
    #1;
    check("async_busy", ex_busy, 1'b0);
    check("async_outs", outs, '0);
    @(negedge clk);
    reset = 1'b1;
    lw();
    step();
    check("post_reset_lw", {ex_busy, ex_mem_alu_result}, {1'b0, 32'h1004});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
